// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants, types and helpers for the 4-digit display scan sequencer.
// Edit-field codes and enable-bit positions match the display's mapping.
package display_scan_ctrl_pkg;

  localparam logic [1:0] EDIT_NONE  = 2'b00;
  localparam logic [1:0] EDIT_HOURS = 2'b01;
  localparam logic [1:0] EDIT_MINS  = 2'b10;

  localparam int DIG1_EN = 3;
  localparam int DIG2_EN = 2;
  localparam int DIG3_EN = 1;
  localparam int DIG4_EN = 0;

  localparam logic [1:0] SEL_DIG1 = 2'b00;
  localparam logic [1:0] SEL_DIG4 = 2'b11;

  typedef enum logic {
    PHASE_HIDDEN  = 1'b0,
    PHASE_VISIBLE = 1'b1
  } blink_phase_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Code 2'b11 is treated the same as no edit.
  function automatic logic edit_active(input logic [1:0] field);
    return (field == EDIT_HOURS) || (field == EDIT_MINS);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle between control_unit/display and the scan sequencer.
// master drives the edit/tick controls and consumes the scan outputs.
interface display_scan_ctrl_if;

  logic [1:0] edit_field;
  logic       blink_restart;
  logic       sec_tick;
  logic [3:0] data_dig1;
  logic [1:0] select;
  logic [3:0] enable_digits;
  logic       enable_dot;

  modport master (
    output edit_field,
    output blink_restart,
    output sec_tick,
    output data_dig1,
    input  select,
    input  enable_digits,
    input  enable_dot
  );

  modport slave (
    input  edit_field,
    input  blink_restart,
    input  sec_tick,
    input  data_dig1,
    output select,
    output enable_digits,
    output enable_dot
  );

endinterface

// File: rtl/display_scan_ctrl_mod_counter.sv
// Modulo-N counter with enable and synchronous clear; clear beats enable.
// o_Wrap flags the enabled terminal count combinationally.
module mod_counter
  import display_scan_ctrl_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_En,
  input  logic                  i_Clr,
  output logic [cnt_width(N)-1:0] o_Count,
  output logic                  o_Wrap
);

  localparam int W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_next;

  assign o_Wrap  = i_En && (count_reg == LAST);
  assign o_Count = count_reg;

  always_comb begin
    count_next = count_reg;
    if (i_Clr) begin
      count_next = '0;
    end else if (i_En) begin
      count_next = o_Wrap ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed digit scan for a 4-digit 7-segment display: dead time,
// edit-field blinking, tens-of-hours blanking and colon-dot sequencing.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64,
  parameter int LZ_SUPPRESS  = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  display_scan_ctrl_if.slave   bus
);

  localparam int SCAN_W  = cnt_width(SCAN_DIV);
  localparam int FRAME_W = cnt_width(BLINK_FRAMES);

  logic [SCAN_W-1:0]  scan_cnt;
  logic               scan_wrap;
  logic [FRAME_W-1:0] frame_cnt;
  logic               frame_en;
  logic               frame_wrap;

  logic [1:0]         sel_reg;
  blink_phase_e       phase_reg;
  logic               dot_reg;

  logic               edit_on;
  logic               in_dead_time;
  logic               lz_blank;
  logic [3:0]         field_hide;

  mod_counter #(.N(SCAN_DIV)) u_scan_cnt (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_En    (1'b1),
    .i_Clr   (1'b0),
    .o_Count (scan_cnt),
    .o_Wrap  (scan_wrap)
  );

  // A frame ends when the last digit's slot wraps back to Dig1.
  assign frame_en = scan_wrap && (sel_reg == SEL_DIG4);

  mod_counter #(.N(BLINK_FRAMES)) u_frame_cnt (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_En    (frame_en),
    .i_Clr   (bus.blink_restart),
    .o_Count (frame_cnt),
    .o_Wrap  (frame_wrap)
  );

  assign edit_on = edit_active(bus.edit_field);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sel_reg   <= SEL_DIG1;
      phase_reg <= PHASE_VISIBLE;
      dot_reg   <= 1'b0;
    end else begin
      if (scan_wrap) begin
        sel_reg <= sel_reg + 2'd1;
      end
      // A restart press wins over a frame wrap landing on the same clock.
      if (bus.blink_restart) begin
        phase_reg <= PHASE_VISIBLE;
      end else if (frame_wrap) begin
        phase_reg <= (phase_reg == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
      end
      if (!edit_on && bus.sec_tick) begin
        dot_reg <= ~dot_reg;
      end
    end
  end

  assign in_dead_time = (scan_cnt < SCAN_W'(BLANK_CYC));
  assign lz_blank     = (LZ_SUPPRESS != 0) && (bus.data_dig1 == 4'd0);

  always_comb begin
    field_hide = 4'b0000;
    if (phase_reg == PHASE_HIDDEN) begin
      if (bus.edit_field == EDIT_HOURS) begin
        field_hide[DIG1_EN] = 1'b1;
        field_hide[DIG2_EN] = 1'b1;
      end else if (bus.edit_field == EDIT_MINS) begin
        field_hide[DIG3_EN] = 1'b1;
        field_hide[DIG4_EN] = 1'b1;
      end
    end
  end

  // Per-digit enable: dead time blanks all, then blink and leading-zero masks.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit_en
    if (gi == DIG1_EN) begin : g_dig1
      assign bus.enable_digits[gi] = !in_dead_time && !field_hide[gi] && !lz_blank;
    end else begin : g_other
      assign bus.enable_digits[gi] = !in_dead_time && !field_hide[gi];
    end
  end

  assign bus.select     = sel_reg;
  assign bus.enable_dot = edit_on ? 1'b1 : dot_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a tiny scan geometry
// (8 clocks/slot, 2 dead clocks, 2 frames per blink half-period).
module tb_display_scan_ctrl;

  logic clk;
  logic rst;
  int   k;
  int   n_checks;
  int   n_fail;

  display_scan_ctrl_if bus ();

  display_scan_ctrl #(
    .SCAN_DIV     (8),
    .BLANK_CYC    (2),
    .BLINK_FRAMES (2),
    .LZ_SUPPRESS  (1)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         adv;
    logic [1:0] edit;
    logic [3:0] dig1;
    logic [1:0] sel;
    logic [3:0] en;
    logic       dot;
    string      name;
  } vec_t;

  vec_t vec [21];

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_to(input int target);
    while (k < target) advance(1);
  endtask

  task automatic check_sel(input string name, input logic [1:0] exp);
    #1;
    n_checks++;
    if (bus.select !== exp) begin
      n_fail++;
      $display("FAIL %s sel: got %b expected %b (k=%0d)", name, bus.select, exp, k);
    end
  endtask

  task automatic check_en(input string name, input logic [3:0] exp);
    #1;
    n_checks++;
    if (bus.enable_digits !== exp) begin
      n_fail++;
      $display("FAIL %s en: got %b expected %b (k=%0d)", name, bus.enable_digits, exp, k);
    end
  endtask

  task automatic check_dot(input string name, input logic exp);
    #1;
    n_checks++;
    if (bus.enable_dot !== exp) begin
      n_fail++;
      $display("FAIL %s dot: got %b expected %b (k=%0d)", name, bus.enable_dot, exp, k);
    end
  endtask

  task automatic pulse_tick();
    bus.sec_tick = 1'b1;
    advance(1);
    bus.sec_tick = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    k        = 0;
    rst                = 1'b1;
    bus.edit_field     = 2'b00;
    bus.blink_restart  = 1'b0;
    bus.sec_tick       = 1'b0;
    bus.data_dig1      = 4'd1;

    //            adv edit   dig1  sel    en       dot
    vec[0]  = '{  0, 2'b00, 4'd1, 2'd0, 4'b0000, 1'b0, "reset"};
    vec[1]  = '{  1, 2'b00, 4'd1, 2'd0, 4'b0000, 1'b0, "dead1"};
    vec[2]  = '{  1, 2'b00, 4'd1, 2'd0, 4'b1111, 1'b0, "slot0_on"};
    vec[3]  = '{  5, 2'b00, 4'd1, 2'd0, 4'b1111, 1'b0, "slot0_end"};
    vec[4]  = '{  1, 2'b00, 4'd1, 2'd1, 4'b0000, 1'b0, "slot1_dead"};
    vec[5]  = '{  2, 2'b00, 4'd1, 2'd1, 4'b1111, 1'b0, "slot1_on"};
    vec[6]  = '{  6, 2'b00, 4'd1, 2'd2, 4'b0000, 1'b0, "slot2_dead"};
    vec[7]  = '{  8, 2'b00, 4'd1, 2'd3, 4'b0000, 1'b0, "slot3_dead"};
    vec[8]  = '{  4, 2'b00, 4'd1, 2'd3, 4'b1111, 1'b0, "slot3_on"};
    vec[9]  = '{  4, 2'b00, 4'd1, 2'd0, 4'b0000, 1'b0, "sel_wrap"};
    vec[10] = '{  2, 2'b10, 4'd1, 2'd0, 4'b1111, 1'b1, "mins_frame1"};
    vec[11] = '{ 30, 2'b10, 4'd1, 2'd0, 4'b0000, 1'b1, "mins_f2_dead"};
    vec[12] = '{  2, 2'b10, 4'd1, 2'd0, 4'b1100, 1'b1, "mins_f2_hide"};
    vec[13] = '{ 33, 2'b10, 4'd1, 2'd0, 4'b1100, 1'b1, "mins_f3_hide"};
    vec[14] = '{ 29, 2'b10, 4'd1, 2'd0, 4'b0000, 1'b1, "mins_f4_dead"};
    vec[15] = '{  2, 2'b10, 4'd1, 2'd0, 4'b1111, 1'b1, "mins_f4_show"};
    vec[16] = '{  1, 2'b00, 4'd0, 2'd0, 4'b0111, 1'b0, "lz_blank"};
    vec[17] = '{  0, 2'b00, 4'd2, 2'd0, 4'b1111, 1'b0, "lz_release"};
    vec[18] = '{ 63, 2'b01, 4'd0, 2'd0, 4'b0011, 1'b1, "hours_hide_lz"};
    vec[19] = '{  0, 2'b10, 4'd0, 2'd0, 4'b0100, 1'b1, "mins_hide_lz"};
    vec[20] = '{  0, 2'b11, 4'd1, 2'd0, 4'b1111, 1'b0, "edit11_none"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    k   = 0;

    for (int i = 0; i < 21; i++) begin
      bus.edit_field = vec[i].edit;
      bus.data_dig1  = vec[i].dig1;
      advance(vec[i].adv);
      check_sel(vec[i].name, vec[i].sel);
      check_en(vec[i].name, vec[i].en);
      check_dot(vec[i].name, vec[i].dot);
    end

    // Blink restart pressed during a hidden frame (k=194..255 would be hidden).
    bus.edit_field = 2'b01;
    bus.data_dig1  = 4'd1;
    run_to(202);
    check_en("restart_before", 4'b0011);
    bus.blink_restart = 1'b1;
    advance(1);
    bus.blink_restart = 1'b0;
    check_sel("restart_sel", 2'd1);
    check_en("restart_next", 4'b1111);
    run_to(254);
    check_en("restart_hold", 4'b1111);
    run_to(258);
    check_en("restart_expire", 4'b0011);

    // Colon dot sequencing across edit mode.
    bus.edit_field = 2'b00;
    pulse_tick();
    check_dot("tick1", 1'b1);
    pulse_tick();
    check_dot("tick2", 1'b0);
    pulse_tick();
    check_dot("tick3", 1'b1);
    bus.edit_field = 2'b01;
    check_dot("edit_steady", 1'b1);
    pulse_tick();
    check_dot("edit_tick", 1'b1);
    bus.edit_field = 2'b00;
    check_dot("resume", 1'b1);
    pulse_tick();
    check_dot("tick4", 1'b0);
    bus.edit_field = 2'b01;
    check_dot("edit_force", 1'b1);
    pulse_tick();
    bus.edit_field = 2'b00;
    check_dot("edit_hold0", 1'b0);
    pulse_tick();
    check_dot("tick5", 1'b1);

    // Reset in the middle of a hidden-phase slot, with a coincident tick.
    bus.edit_field = 2'b10;
    run_to(309);
    check_sel("pre_reset_sel", 2'd2);
    check_en("pre_reset_en", 4'b1100);
    bus.edit_field = 2'b00;
    check_dot("pre_reset_dot", 1'b1);
    rst          = 1'b1;
    bus.sec_tick = 1'b1;
    advance(1);
    rst          = 1'b0;
    bus.sec_tick = 1'b0;
    k            = 0;
    check_sel("post_reset_sel", 2'd0);
    check_en("post_reset_en", 4'b0000);
    check_dot("post_reset_dot", 1'b0);
    bus.edit_field = 2'b01;
    run_to(2);
    check_en("post_reset_phase", 4'b1111);
    bus.edit_field = 2'b00;
    check_dot("post_reset_dot2", 1'b0);
    run_to(8);
    check_sel("post_reset_slot1", 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
